// File: rtl/adc_boxcar_decimator_if.sv
// adc_boxcar_decimator_if
//   AXI-Stream style channel used for both the ADC input stream and the
//   decimated output stream of adc_boxcar_decimator.
//   tdata  : stream word
//   tvalid : beat valid (driven by master)
//   tready : beat accept (driven by slave)
interface adc_boxcar_decimator_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_boxcar_decimator.sv
// adc_boxcar_decimator
//   Removes a DC offset from each ADC sample (saturating to the ADC range),
//   then averages blocks of 2^LOG2_DECIM accepted samples and emits one mean
//   per block, scaled by 4 (2 fractional bits), on a backpressured stream.
//   Means that arrive while the output register is still held are dropped
//   and counted.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   enable      run control; low discards the partial block
//   offset      signed DC offset subtracted from every sample
//   s_axis_in   ADC stream (slave); sample in tdata[ADC_WIDTH-1:0]
//   m_axis_out  mean stream (master); mean sign-extended to the bus width
//   drop_count  means lost to backpressure, saturating
//   block_count completed blocks, delivered or dropped, wrapping
module adc_boxcar_decimator #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_DECIM       = 10,
  parameter int OUT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [ADC_WIDTH-1:0] offset,
  adc_boxcar_decimator_if.slave       s_axis_in,
  adc_boxcar_decimator_if.master      m_axis_out,
  output logic [15:0]                 drop_count,
  output logic [31:0]                 block_count
);

  localparam int ACC_W = ADC_WIDTH + LOG2_DECIM;
  localparam int SHIFT = LOG2_DECIM - 2;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Clamp a one-bit-wider difference back into the ADC range.
  function automatic logic signed [ADC_WIDTH-1:0] sat_adc(input logic signed [ADC_WIDTH:0] x);
    if (x[ADC_WIDTH] != x[ADC_WIDTH-1])
      return x[ADC_WIDTH] ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : {1'b0, {(ADC_WIDTH-1){1'b1}}};
    return x[ADC_WIDTH-1:0];
  endfunction

  // Block mean with 2 fractional bits; arithmetic shift rounds toward -inf.
  function automatic logic signed [ACC_W-1:0] round_floor(input logic signed [ACC_W-1:0] sum);
    return sum >>> SHIFT;
  endfunction

  state_t state, state_nxt;
  logic   run;

  logic                        beat;
  logic signed [ADC_WIDTH-1:0] sample;
  logic signed [ADC_WIDTH:0]   diff;

  logic signed [ADC_WIDTH-1:0] d_p1;
  logic                        vld_p1;

  logic signed [ACC_W-1:0]     acc_p2;
  logic [LOG2_DECIM-1:0]       cnt_p2;
  logic signed [ACC_W-1:0]     sum_p2;
  logic signed [ACC_W-1:0]     shifted_p2;
  logic signed [OUT_WIDTH-1:0] mean_p2;
  logic                        take_p2;
  logic                        last_p2;

  logic [AXIS_TDATA_WIDTH-1:0] data_p3;
  logic                        vld_p3;

  // Upper input bits and the sign copies above the mean are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axis_in.tdata, shifted_p2};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = ACCUM;
      ACCUM:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Samples are only captured and summed while ACCUM is held with enable
  // still high, so a falling enable also kills the sample in flight.
  always_comb begin
    run = 1'b0;
    if (state == ACCUM && enable) run = 1'b1;
  end

  assign s_axis_in.tready = rst;
  assign beat             = s_axis_in.tvalid & s_axis_in.tready;
  assign sample           = s_axis_in.tdata[ADC_WIDTH-1:0];
  assign diff             = {sample[ADC_WIDTH-1], sample} - {offset[ADC_WIDTH-1], offset};

  // Stage 1: offset removal and saturation
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= beat & run;
  end

  always_ff @(posedge clk) begin
    if (beat) d_p1 <= sat_adc(diff);
  end

  // Stage 2: block accumulation
  assign take_p2    = vld_p1 & run;
  assign last_p2    = take_p2 & (&cnt_p2);
  assign sum_p2     = acc_p2 + {{LOG2_DECIM{d_p1[ADC_WIDTH-1]}}, d_p1};
  assign shifted_p2 = round_floor(sum_p2);
  assign mean_p2    = shifted_p2[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
    end else if (take_p2) begin
      // The next block starts on the same edge that closes this one.
      acc_p2 <= last_p2 ? '0 : sum_p2;
      cnt_p2 <= cnt_p2 + LOG2_DECIM'(1);
    end
  end

  // Stage 3: single-entry output register with drop accounting
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p3      <= 1'b0;
      data_p3     <= '0;
      drop_count  <= '0;
      block_count <= '0;
    end else if (last_p2) begin
      block_count <= block_count + 32'd1;
      if (!vld_p3 || m_axis_out.tready) begin
        vld_p3  <= 1'b1;
        data_p3 <= {{(AXIS_TDATA_WIDTH-OUT_WIDTH){mean_p2[OUT_WIDTH-1]}}, mean_p2};
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (vld_p3 && m_axis_out.tready) begin
      vld_p3 <= 1'b0;
    end
  end

  assign m_axis_out.tvalid = vld_p3;
  assign m_axis_out.tdata  = data_p3;

endmodule

// File: tb/tb_adc_boxcar_decimator.sv
// tb_adc_boxcar_decimator
//   Self-checking bench for adc_boxcar_decimator: directed blocks with
//   hand-computed means followed by a randomized stream, all checked every
//   cycle against a behavioural block-average model.
module tb_adc_boxcar_decimator;
  localparam int L = 10;
  localparam int N = 1 << L;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic signed [13:0] offset;
  logic [15:0]       drop_count;
  logic [31:0]       block_count;

  adc_boxcar_decimator_if #(.AXIS_TDATA_WIDTH(32)) s_if ();
  adc_boxcar_decimator_if #(.AXIS_TDATA_WIDTH(32)) m_if ();

  adc_boxcar_decimator #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .LOG2_DECIM(L), .OUT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .offset(offset),
    .s_axis_in(s_if), .m_axis_out(m_if),
    .drop_count(drop_count), .block_count(block_count)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h (%0d) want 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  // Behavioural model: a sample joins the running block only if enable was
  // high on the edge before its acceptance, on its acceptance edge and on
  // the following edge; any low enable throws the partial block away.
  bit          m_armed = 0;
  bit          m_en_prev, m_pv, m_full;
  int          m_pd, m_sum, m_n, m_out, m_drop;
  logic [31:0] m_blocks;

  always @(posedge clk) begin : model_p
    int d, mean;
    bit done;
    logic signed [13:0] smp;
    if (!rst) begin
      m_armed = 1; m_en_prev = 0; m_pv = 0; m_full = 0;
      m_sum = 0; m_n = 0; m_out = 0; m_drop = 0; m_blocks = 0; m_pd = 0;
    end else begin
      done = 0;
      mean = 0;
      if (!enable) begin
        m_sum = 0; m_n = 0;
      end else if (m_pv) begin
        m_sum += m_pd;
        m_n++;
        if (m_n == N) begin
          done  = 1;
          mean  = m_sum >>> (L - 2);
          m_sum = 0;
          m_n   = 0;
        end
      end
      smp = s_if.tdata[13:0];
      d = int'(smp) - int'(offset);
      if (d > 8191) d = 8191;
      else if (d < -8192) d = -8192;
      m_pd = d;
      m_pv = s_if.tvalid && m_en_prev && enable;
      m_en_prev = enable;
      if (done) begin
        m_blocks = m_blocks + 32'd1;
        if (!m_full || m_if.tready) begin
          m_full = 1;
          m_out  = mean;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end else if (m_full && m_if.tready) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("tready", 32'(s_if.tready), 32'(rst));
      check("tvalid", 32'(m_if.tvalid), 32'(m_full));
      if (m_full) check("tdata", m_if.tdata, m_out);
      check("drop_count", {16'b0, drop_count}, m_drop);
      check("block_count", block_count, m_blocks);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && m_if.tvalid && m_if.tready) got.push_back(m_if.tdata);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    logic [31:0] w;
    w = $urandom();
    w[13:0] = v[13:0];
    s_if.tdata  = w;
    s_if.tvalid = 1'b1;
    tick();
  endtask

  task automatic settle();
    s_if.tvalid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_got(input string name, input int n, input logic [31:0] e0, input logic [31:0] e1);
    check({name, " count"}, got.size(), n);
    if (n >= 1 && got.size() >= 1) check({name, " first"}, got[0], e0);
    if (n >= 2 && got.size() >= 2) check({name, " second"}, got[1], e1);
    got.delete();
  endtask

  task automatic reset_literals(input string name);
    check({name, " tready"}, 32'(s_if.tready), 0);
    check({name, " tvalid"}, 32'(m_if.tvalid), 0);
    check({name, " tdata"}, m_if.tdata, 0);
    check({name, " drop_count"}, {16'b0, drop_count}, 0);
    check({name, " block_count"}, block_count, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] w;
    rst = 1'b0; enable = 1'b0; offset = '0;
    s_if.tdata = '0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    repeat (3) tick();
    reset_literals("reset");
    rst = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    for (int i = 0; i < N; i++) beat(100);
    s_if.tvalid = 1'b0;
    lat = 0;
    while (!m_if.tvalid && lat < 8) begin
      tick();
      lat++;
    end
    check("const100 edges after last accept", lat, 1);
    check("const100 tdata", m_if.tdata, 32'h0000_0190);
    check("const100 block_count", block_count, 1);
    settle();
    check_got("const100", 1, 400, 0);

    for (int i = 0; i < N; i++) beat(i);
    for (int i = 0; i < N; i++) beat(-5);
    settle();
    check_got("ramp then -5", 2, 2046, 32'hFFFF_FFEC);

    offset = 14'sd100;
    for (int i = 0; i < N; i++) beat(-8192);
    offset = -14'sd100;
    for (int i = 0; i < N; i++) beat(8191);
    settle();
    offset = '0;
    check_got("saturation", 2, 32'hFFFF_8000, 32764);

    for (int i = 0; i < N; i++) begin
      beat(7);
      s_if.tvalid = 1'b0;
      tick();
    end
    settle();
    check_got("gapped 7", 1, 28, 0);

    m_if.tready = 1'b0;
    for (int b = 1; b <= 3; b++)
      for (int i = 0; i < N; i++) beat(b);
    settle();
    check("backpressure tvalid", 32'(m_if.tvalid), 1);
    check("backpressure held tdata", m_if.tdata, 4);
    check("backpressure drop_count", {16'b0, drop_count}, 2);
    check("backpressure block_count", block_count, 9);
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    check("backpressure tvalid after accept", 32'(m_if.tvalid), 0);
    m_if.tready = 1'b1;
    check_got("backpressure", 1, 4, 0);

    for (int i = 0; i < 500; i++) beat(9);
    enable = 1'b0;
    beat(9);
    beat(9);
    s_if.tvalid = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    for (int i = 0; i < N - 1; i++) beat(3);
    settle();
    check_got("enable partial discarded", 0, 0, 0);
    beat(3);
    settle();
    check_got("enable new block", 1, 12, 0);
    check("enable block_count", block_count, 10);

    m_if.tready = 1'b0;
    for (int i = 0; i < N; i++) beat(1);
    for (int i = 0; i < 300; i++) beat(50);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    tick();
    reset_literals("mid-block reset");
    got.delete();
    rst = 1'b1;
    m_if.tready = 1'b1;
    tick();

    for (int c = 0; c < 12000; c++) begin
      w = $urandom();
      s_if.tdata  = w;
      s_if.tvalid = ($urandom_range(3) != 0);
      m_if.tready = ($urandom_range(4) != 0);
      enable      = ($urandom_range(2999) != 0);
      if ($urandom_range(499) == 0) offset = 14'($urandom());
      tick();
    end
    enable = 1'b1;
    m_if.tready = 1'b1;
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
